// File: rtl/ring_scan_display.sv
// Checks a one-hot ring phase bus, counts revolutions and scans a 4-digit BCD value onto a 7-seg display.
// Latency phase -> an/seg/idx/err 2 cycles; ld_ready drops while a loaded value waits for the next revolution boundary.
module ring_scan_display #(
  parameter int REV_W      = 8,
  parameter bit ALLOW_HOLD = 1'b0
) (
  input  logic             clock,
  input  logic             Resetn,
  input  logic [3:0]       phase,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [15:0]      ld_data,
  input  logic             clr_err,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic [1:0]       idx,
  output logic [REV_W-1:0] rev_cnt,
  output logic             err,
  output logic [1:0]       err_code
);

  logic [3:0]       phase_q, phase_d, prev_q, prev_d;
  logic             run_q, run_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       idx_q, idx_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [15:0]      pend_q, pend_d, shadow_q, shadow_d;
  logic             pend_full_q, pend_full_d;

  logic       zero_hot, multi_hot, cur_legal, prev_legal, seq_err, wrap, accept;
  logic [3:0] succ, digit;
  logic [1:0] new_code, cur_idx;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    zero_hot   = (phase_q == 4'b0000);
    multi_hot  = ((phase_q & (phase_q - 4'd1)) != 4'b0000);
    cur_legal  = !zero_hot && !multi_hot;
    prev_legal = (prev_q != 4'b0000) && ((prev_q & (prev_q - 4'd1)) == 4'b0000);
    succ       = {prev_q[0], prev_q[3:1]};
    seq_err    = cur_legal && prev_legal && (phase_q != succ) &&
                 !(ALLOW_HOLD && (phase_q == prev_q));
    // phase_q still holds its reset value until the first post-reset sample lands
    new_code = 2'd0;
    if (run_q) begin
      if (zero_hot)       new_code = 2'd1;
      else if (multi_hot) new_code = 2'd2;
      else if (seq_err)   new_code = 2'd3;
    end
    wrap   = (prev_q == 4'b0010) && (phase_q == 4'b0001) && (new_code == 2'd0);
    accept = ld_valid && !pend_full_q;
    case (phase_q)
      4'b1000: cur_idx = 2'd1;
      4'b0100: cur_idx = 2'd2;
      4'b0010: cur_idx = 2'd3;
      default: cur_idx = 2'd0;
    endcase
  end

  always_comb begin
    phase_d     = phase;
    prev_d      = phase_q;
    run_d       = 1'b1;
    an_d        = an_q;
    seg_d       = seg_q;
    idx_d       = idx_q;
    rev_d       = rev_q;
    err_d       = err_q;
    code_d      = code_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    shadow_d    = shadow_q;

    if (new_code != 2'd0) begin
      err_d = 1'b1;
      if (!err_q || clr_err) code_d = new_code;
    end else if (clr_err) begin
      err_d  = 1'b0;
      code_d = 2'd0;
    end

    if (wrap) begin
      rev_d = rev_q + REV_W'(1);
      if (pend_full_q) begin
        shadow_d    = pend_q;
        pend_full_d = 1'b0;
      end
    end
    if (accept) begin
      pend_d      = ld_data;
      pend_full_d = 1'b1;
    end

    // Decode from the post-commit shadow so digit 0 of a new revolution already shows new data
    digit = shadow_d[{cur_idx, 2'b00} +: 4];
    if (cur_legal) begin
      an_d  = ~phase_q;
      idx_d = cur_idx;
      seg_d = seg_decode(digit);
    end else begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end
  end

  always_ff @(posedge clock) begin
    if (!Resetn) begin
      phase_q     <= 4'b0000;
      prev_q      <= 4'b0000;
      run_q       <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      idx_q       <= 2'd0;
      rev_q       <= '0;
      err_q       <= 1'b0;
      code_q      <= 2'd0;
      pend_q      <= 16'h0000;
      pend_full_q <= 1'b0;
      shadow_q    <= 16'h0000;
    end else begin
      phase_q     <= phase_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      idx_q       <= idx_d;
      rev_q       <= rev_d;
      err_q       <= err_d;
      code_q      <= code_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      shadow_q    <= shadow_d;
    end
  end

  assign ld_ready = !pend_full_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign idx      = idx_q;
  assign rev_cnt  = rev_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_ring_scan_display.sv
// Table-driven bench for ring_scan_display: default, ALLOW_HOLD=1 and REV_W=2 instances share one stimulus stream.
`timescale 1ns/1ps
module tb_ring_scan_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111, SB = 7'b1111111;

  logic        clock = 1'b0;
  logic        Resetn, ld_valid, clr_err;
  logic [3:0]  phase;
  logic [15:0] ld_data;

  logic       rdy, rdy_h, rdy_r, err, err_h, err_r;
  logic [3:0] an, an_h, an_r;
  logic [6:0] seg, seg_h, seg_r;
  logic [1:0] idx, idx_h, idx_r, code, code_h, code_r;
  logic [7:0] rev, rev_h;
  logic [1:0] rev_r;

  always #5 clock = ~clock;

  ring_scan_display dut (
    .clock(clock), .Resetn(Resetn), .phase(phase), .ld_valid(ld_valid), .ld_ready(rdy),
    .ld_data(ld_data), .clr_err(clr_err), .an(an), .seg(seg), .idx(idx),
    .rev_cnt(rev), .err(err), .err_code(code));

  ring_scan_display #(.ALLOW_HOLD(1'b1)) dut_h (
    .clock(clock), .Resetn(Resetn), .phase(phase), .ld_valid(ld_valid), .ld_ready(rdy_h),
    .ld_data(ld_data), .clr_err(clr_err), .an(an_h), .seg(seg_h), .idx(idx_h),
    .rev_cnt(rev_h), .err(err_h), .err_code(code_h));

  ring_scan_display #(.REV_W(2)) dut_r (
    .clock(clock), .Resetn(Resetn), .phase(phase), .ld_valid(ld_valid), .ld_ready(rdy_r),
    .ld_data(ld_data), .clr_err(clr_err), .an(an_r), .seg(seg_r), .idx(idx_r),
    .rev_cnt(rev_r), .err(err_r), .err_code(code_r));

  typedef struct {
    logic [3:0]  ph;
    logic        clr;
    logic        lv;
    logic [15:0] ld;
    logic        chk;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  idx;
    logic        err;
    logic [1:0]  code;
    logic        errh;
    logic [1:0]  codeh;
    logic [7:0]  rev;
    logic        rchk;
    logic        rdy;
  } vec_t;

  typedef struct {
    logic [3:0] ph;
    logic [3:0] an;
    logic [1:0] idx;
    logic [6:0] sa;
    logic [6:0] sb;
  } ring_t;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] ph, input logic clr, input logic chk,
                              input logic [3:0] an_e, input logic [6:0] seg_e, input logic [1:0] idx_e,
                              input logic err_e, input logic [1:0] code_e, input logic errh_e,
                              input logic [1:0] codeh_e, input logic [7:0] rev_e);
    vec_t v;
    v.ph = ph; v.clr = clr; v.lv = 1'b0; v.ld = 16'h0000; v.chk = chk;
    v.an = an_e; v.seg = seg_e; v.idx = idx_e; v.err = err_e; v.code = code_e;
    v.errh = errh_e; v.codeh = codeh_e; v.rev = rev_e; v.rchk = 1'b0; v.rdy = 1'b0;
    return v;
  endfunction

  // Drive one cycle; the outputs seen after this edge belong to the vector driven one cycle earlier.
  task automatic cyc(input vec_t v);
    vec_t e;
    phase = v.ph; clr_err = v.clr; ld_valid = v.lv; ld_data = v.ld;
    sb_q.push_back(v);
    @(posedge clock); #1;
    if (v.rchk) check("ld_ready", 32'(rdy), 32'(v.rdy));
    if (sb_q.size() == 2) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        check("an", 32'(an), 32'(e.an));
        check("seg", 32'(seg), 32'(e.seg));
        check("idx", 32'(idx), 32'(e.idx));
        check("err", 32'(err), 32'(e.err));
        check("err_code", 32'(code), 32'(e.code));
        check("rev_cnt", 32'(rev), 32'(e.rev));
        check("rev_cnt_w2", 32'(rev_r), 32'(e.rev[1:0]));
        check("err_w2", 32'(err_r), 32'(e.err));
        check("err_hold", 32'(err_h), 32'(e.errh));
        check("err_code_hold", 32'(code_h), 32'(e.codeh));
      end
    end
  endtask

  ring_t ring[4];
  vec_t  et[16];

  initial begin
    vec_t v;
    ring[0] = '{ph: 4'b0001, an: 4'b1110, idx: 2'd0, sa: S1, sb: S5};
    ring[1] = '{ph: 4'b1000, an: 4'b0111, idx: 2'd1, sa: S2, sb: S0};
    ring[2] = '{ph: 4'b0100, an: 4'b1011, idx: 2'd2, sa: S3, sb: SD};
    ring[3] = '{ph: 4'b0010, an: 4'b1101, idx: 2'd3, sa: S4, sb: S9};

    //           ph       clr   chk   an       seg idx   err   code  errh  codeh rev
    et[0]  = mk(4'b0000, 1'b0, 1'b1, 4'b1111, SB, 2'd3, 1'b1, 2'd1, 1'b1, 2'd1, 8'd7);
    et[1]  = mk(4'b0000, 1'b0, 1'b1, 4'b1111, SB, 2'd3, 1'b1, 2'd1, 1'b1, 2'd1, 8'd7);
    et[2]  = mk(4'b0000, 1'b1, 1'b1, 4'b1111, SB, 2'd3, 1'b1, 2'd1, 1'b1, 2'd1, 8'd7);
    et[3]  = mk(4'b0001, 1'b0, 1'b1, 4'b1110, S5, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 8'd7);
    et[4]  = mk(4'b1000, 1'b1, 1'b1, 4'b0111, S0, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 8'd7);
    et[5]  = mk(4'b0101, 1'b0, 1'b1, 4'b1111, SB, 2'd1, 1'b1, 2'd2, 1'b1, 2'd2, 8'd7);
    et[6]  = mk(4'b0100, 1'b0, 1'b1, 4'b1011, SD, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 8'd7);
    et[7]  = mk(4'b0010, 1'b1, 1'b1, 4'b1101, S9, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 8'd7);
    et[8]  = mk(4'b0001, 1'b0, 1'b1, 4'b1110, S5, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 8'd8);
    et[9]  = mk(4'b0100, 1'b0, 1'b1, 4'b1011, SD, 2'd2, 1'b1, 2'd3, 1'b1, 2'd3, 8'd8);
    et[10] = mk(4'b0010, 1'b1, 1'b1, 4'b1101, S9, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 8'd8);
    et[11] = mk(4'b0001, 1'b1, 1'b1, 4'b1110, S5, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 8'd9);
    et[12] = mk(4'b0001, 1'b0, 1'b1, 4'b1110, S5, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0, 8'd9);
    et[13] = mk(4'b1000, 1'b0, 1'b1, 4'b0111, S0, 2'd1, 1'b1, 2'd3, 1'b0, 2'd0, 8'd9);
    et[14] = mk(4'b0100, 1'b0, 1'b0, 4'b1111, SB, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 8'd0);
    et[15] = mk(4'b0000, 1'b0, 1'b0, 4'b1111, SB, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 8'd0);
    et[14].lv = 1'b1; et[14].ld = 16'h7777; et[14].rchk = 1'b1; et[14].rdy = 1'b0;

    Resetn = 1'b0; phase = 4'b0000; ld_valid = 1'b0; ld_data = 16'h0000; clr_err = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_an", 32'(an), 32'(4'b1111));
    check("rst_seg", 32'(seg), 32'(SB));
    check("rst_idx", 32'(idx), 32'(2'd0));
    check("rst_rev", 32'(rev), 32'(8'd0));
    check("rst_err", 32'(err), 32'(1'b0));
    check("rst_code", 32'(code), 32'(2'd0));
    check("rst_ld_ready", 32'(rdy), 32'(1'b1));
    Resetn = 1'b1;

    // Pass 0 shows the zero shadow while 0x4321 waits; passes 1-6 show 4321; 0x9A05 loads mid pass 6.
    for (int p = 0; p < 8; p++) begin
      for (int s = 0; s < 4; s++) begin
        v = mk(ring[s].ph, 1'b0, 1'b1, ring[s].an,
               (p == 0) ? S0 : ((p == 7) ? ring[s].sb : ring[s].sa),
               ring[s].idx, 1'b0, 2'd0, 1'b0, 2'd0, 8'(p));
        if (p == 0 && s == 0) begin v.lv = 1'b1; v.ld = 16'h4321; v.rchk = 1'b1; v.rdy = 1'b0; end
        if (p == 6 && s == 0) begin v.rchk = 1'b1; v.rdy = 1'b1; end
        if (p == 6 && s == 1) begin v.lv = 1'b1; v.ld = 16'h9A05; v.rchk = 1'b1; v.rdy = 1'b0; end
        if (p == 6 && s >= 2) begin v.lv = 1'b1; v.ld = 16'h1111; v.rchk = 1'b1; v.rdy = 1'b0; end
        if (p == 7 && s == 0) begin v.rchk = 1'b1; v.rdy = 1'b0; end
        if (p == 7 && s == 1) begin v.rchk = 1'b1; v.rdy = 1'b1; end
        cyc(v);
      end
    end

    for (int i = 0; i < 16; i++) cyc(et[i]);
    sb_q.delete();

    // Mid-run reset with a value pending and the sticky error set.
    check("pre_rst_err", 32'(err), 32'(1'b1));
    Resetn = 1'b0; phase = 4'b0000; ld_valid = 1'b0; clr_err = 1'b0;
    @(posedge clock); #1;
    check("rst2_an", 32'(an), 32'(4'b1111));
    check("rst2_seg", 32'(seg), 32'(SB));
    check("rst2_idx", 32'(idx), 32'(2'd0));
    check("rst2_rev", 32'(rev), 32'(8'd0));
    check("rst2_err", 32'(err), 32'(1'b0));
    check("rst2_code", 32'(code), 32'(2'd0));
    check("rst2_ld_ready", 32'(rdy), 32'(1'b1));
    Resetn = 1'b1; phase = 4'b0001;
    @(posedge clock); #1;
    phase = 4'b1000;
    @(posedge clock); #1;
    check("rst2_an_run", 32'(an), 32'(4'b1110));
    check("rst2_seg_run", 32'(seg), 32'(S0));
    check("rst2_err_run", 32'(err), 32'(1'b0));
    @(posedge clock); #1;
    check("rst2_an_run1", 32'(an), 32'(4'b0111));
    check("rst2_seg_run1", 32'(seg), 32'(S0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ring_scan_display.md
Name: ring_scan_display

Overview:
- Consumer of the 4-bit one-hot ring counter's phase bus.
- Checks the ring for legal one-hot rotation and encodes the active phase to a digit index.
- Counts full revolutions.
- Uses the phase to time-multiplex a 4-digit BCD value onto a common 7-segment display, with tear-free data updates at revolution boundaries.

Parameters:
- REV_W, 8, width of the revolution counter (wraps modulo 2^REV_W).
- ALLOW_HOLD, 0, when 1 a phase equal to the previous phase is legal (ring clocked slower than this block); when 0 a hold is a sequence error.

Ports:
- clock  in  1  system clock, rising edge.
- Resetn  in  1  synchronous, active-low reset.
- phase  in  4  one-hot ring phase; legal rotation 0001 -> 1000 -> 0100 -> 0010 -> 0001.
- ld_valid  in  1  new display value offered.
- ld_ready  out  1  block can accept a value (pending slot empty).
- ld_data  in  16  four BCD digits; digit i = ld_data[4i+3:4i].
- clr_err  in  1  one-cycle pulse, clears sticky error.
- an  out  4  digit enables, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- idx  out  2  encoded phase index.
- rev_cnt  out  REV_W  completed revolutions.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 zero-hot, 2 multi-hot, 3 sequence.

Behaviour:
- Reset: Resetn sampled on rising clock only; while low, every register loads its reset value.
- Reset values: phase_r=0000, prev_r=0000, an=1111, seg=1111111, idx=0, rev_cnt=0, err=0, err_code=0, ld_ready=1, pending empty, shadow=0.
- Stage 1: phase_r <= phase; prev_r <= phase_r.
- Classification of phase_r:
  - 0000 -> zero-hot.
  - More than one bit set -> multi-hot.
  - Otherwise legal.
- Index encoding: 0001->0, 1000->1, 0100->2, 0010->3.
- Sequence check: applied only when both phase_r and prev_r are legal.
  - phase_r must equal the successor of prev_r.
  - Equality is accepted only when ALLOW_HOLD=1.
  - Anything else -> sequence error.
- First cycle after reset: prev_r=0000, so the sequence check is skipped.
- Error latch:
  - On the first detected error, err=1 and err_code holds that code.
  - Later errors do not overwrite the code.
  - clr_err clears err and err_code to 0 next cycle.
  - If clr_err coincides with a new error, the new error wins.
- Wrap event: prev_r=0010 and phase_r=0001, both legal, and no error detected this cycle.
- On a wrap event:
  - rev_cnt increments, modulo 2^REV_W.
  - If pending is full, shadow <= pending and pending is emptied.
- Load handshake:
  - Transfer occurs when ld_valid && ld_ready; pending <= ld_data.
  - ld_ready goes 0 the next cycle.
  - ld_ready returns to 1 the cycle after the commit.
- Accept and wrap in the same cycle: the old pending (if any) commits to shadow; the new data becomes pending.
  - Since ld_ready=0 whenever pending is full, only an empty pending can accept.
  - So same-cycle accept + wrap commits nothing this wrap; the new data commits on the next wrap.
- Stage 2 outputs (registered from the stage-1 result; total latency phase -> an/seg = 2 cycles):
  - If phase_r is legal: an <= ~phase_r, idx <= index, seg <= decode(shadow digit[index]).
  - If phase_r is zero-hot or multi-hot: an <= 1111, seg <= 1111111, idx holds.
- Segment decode: BCD 0-9 uses the standard patterns. Codes 10-15 display a dash (only g lit, seg=0111111).
- Reset mid-operation: a pending load is discarded and shadow cleared; the err flag is cleared.

Test Plan:
- Ring sequence 0001,1000,0100,0010 repeated, shadow 0x4321:
  - From cycle 2, an cycles 1110,0111,1011,1101 and idx 0,1,2,3.
  - seg shows 1,2,3,4; rev_cnt increments once per 4 cycles.
  - err stays 0.
- phase held 0000 (ring reset without set):
  - err=1, err_code=1 two cycles later, an=1111.
  - clr_err with phase still 0000 -> err re-asserts.
- Multi-hot and skip cases:
  - Inject 0101 -> err_code=2.
  - Separately, 0001 then 0100 -> err_code=3.
  - With ALLOW_HOLD=1, 0001,0001 -> no error; with ALLOW_HOLD=0 -> err_code=3.
- Load mid-revolution:
  - Load 0x9A05 at idx=1 -> ld_ready=0 and the old digits continue.
  - At the wrap, shadow=0x9A05: digit1 shows 0, digit2 shows dash (seg=0111111), digit3 shows 9.
  - ld_ready=1 one cycle after the commit.
- REV_W=2, run 5 revolutions -> rev_cnt sequence 1,2,3,0,1.
- Resetn low for one cycle with pending full and err=1 -> all reset values, ld_ready=1, shadow=0000 displayed.
